// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with issue scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // Widest pending vector the popcount helper accepts (ADDR_W up to 10).
  localparam int POP_MAX_W = 1024;

  // Number of set bits; callers zero-extend narrower vectors.
  function automatic logic [31:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: write bypass, hardwired-zero register, busy flag.
module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              pending_bit,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);

  logic hit;
  logic is_zero;

  // Select stored data, forwarded write data, or the constant zero register.
  always_comb begin
    hit     = we && (waddr == raddr);
    is_zero = (ZERO_REG != 0) && (raddr == '0);
    if (is_zero) begin
      rdata = '0;
    end else if (hit) begin
      rdata = wdata;
    end else begin
      rdata = reg_data;
    end
    // A same-cycle write delivers the operand, so it is no longer busy.
    rbusy = pending_bit && !hit;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a pending-write scoreboard for issue control.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  input  logic                     flush,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]    regs [DEPTH];
  logic [DEPTH-1:0]     pending_reg;
  logic [DEPTH-1:0]     pending_next;
  logic [ADDR_W:0]      pend_cnt_reg;
  logic [ADDR_W:0]      pend_cnt_next;
  logic [POP_MAX_W-1:0] pop_vec;
  logic                 we_eff;
  logic                 wr_zero;
  logic                 iss_zero;
  logic                 issue_take;

  // Gate writes while reset is held so the bypass path also reads zero.
  always_comb begin
    we_eff   = we && !reset;
    wr_zero  = (ZERO_REG != 0) && (waddr == '0);
    iss_zero = (ZERO_REG != 0) && (issue_addr == '0);
  end

  // Next scoreboard state: write clears, issue sets (issue wins), flush clears all.
  always_comb begin
    issue_ready  = iss_zero || !pending_reg[issue_addr] ||
                   (we_eff && (waddr == issue_addr));
    issue_take   = issue_en && issue_ready && !iss_zero;
    pending_next = pending_reg;
    if (we_eff) begin
      pending_next[waddr] = 1'b0;
    end
    if (issue_take) begin
      pending_next[issue_addr] = 1'b1;
    end
    if (flush) begin
      pending_next = '0;
    end
    pop_vec              = '0;
    pop_vec[DEPTH-1:0]   = pending_next;
    pend_cnt_next        = (ADDR_W + 1)'(popcount(pop_vec));
  end

  // Register storage; the zero register is never written when hardwired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && !wr_zero) begin
      regs[waddr] <= wdata;
    end
  end

  // Scoreboard bits and their registered population count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg  <= '0;
      pend_cnt_reg <= '0;
    end else begin
      pending_reg  <= pending_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

  assign pend_cnt = pend_cnt_reg;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = raddr[gi*ADDR_W +: ADDR_W];

      rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
      ) u_rp (
        .raddr       (ra),
        .reg_data    (regs[ra]),
        .pending_bit (pending_reg[ra]),
        .we          (we_eff),
        .waddr       (waddr),
        .wdata       (wdata),
        .rdata       (rdata[gi*DATA_W +: DATA_W]),
        .rbusy       (rbusy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard with a pend_cnt scoreboard queue.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        flush;
  logic [5:0]  pend_cnt;

  logic [63:0] rdata_nz;
  logic [1:0]  rbusy_nz;
  logic        issue_ready_nz;
  logic [5:0]  pend_cnt_nz;

  int errors = 0;
  int checks = 0;

  logic [5:0] cnt_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic        e_ir;
    logic [5:0]  e_cnt;
    logic        nz_chk;
    logic [31:0] e_nz_rd0;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .issue_en(issue_en),
    .issue_addr(issue_addr), .issue_ready(issue_ready), .flush(flush),
    .pend_cnt(pend_cnt)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) u_dut_nz (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_nz), .rbusy(rbusy_nz), .issue_en(issue_en),
    .issue_addr(issue_addr), .issue_ready(issue_ready_nz), .flush(flush),
    .pend_cnt(pend_cnt_nz)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic ie, input logic [4:0] ia, input logic fl);
    we         = w;
    waddr      = wa;
    wdata      = wd;
    raddr      = {r1, r0};
    issue_en   = ie;
    issue_addr = ia;
    flush      = fl;
  endtask

  initial begin
    //            we wa    wdata          ra0    ra1    ie ia     fl  rd0            rd1            busy   ir  cnt  nz nz_rd0
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b1, 6'd0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b1, 6'd0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd7, 1'b1, 5'd7, 1'b0, 32'hDEADBEEF, 32'h0, 2'b00, 1'b1, 6'd1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd7, 1'b0, 5'd7, 1'b0, 32'hDEADBEEF, 32'h0, 2'b10, 1'b0, 6'd1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 5'd7, 32'h12,       5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 32'h12, 32'h12, 2'b00, 1'b1, 6'd0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 6'd1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 5'd9, 32'hA5A5,     5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 32'hA5A5, 32'hA5A5, 2'b00, 1'b1, 6'd1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd7, 1'b0, 5'd9, 1'b0, 32'hA5A5, 32'h12, 2'b01, 1'b0, 6'd1, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 32'h0, 32'hA5A5, 2'b10, 1'b1, 6'd1, 1'b1, 32'hFFFFFFFF};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 6'd1, 1'b1, 32'hFFFFFFFF};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd1, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 6'd2, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 6'd3, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 6'd4, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        5'd1, 5'd4, 1'b1, 5'd4, 1'b1, 32'h0, 32'h0, 2'b01, 1'b1, 6'd0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd3, 1'b0, 5'd4, 1'b0, 32'hA5A5, 32'h0, 2'b00, 1'b1, 6'd0, 1'b0, 32'h0};

    // Reset held: writes and issues must have no visible effect.
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h3333, 5'd3, 5'd3, 1'b1, 5'd3, 1'b0);
    #1;
    chk("rst_rdata0", rdata[31:0], 32'h0);
    chk("rst_rbusy", 32'(rbusy), 32'h0);
    chk("rst_issue_ready", 32'(issue_ready), 32'h1);
    @(posedge clk); #1;
    chk("rst_pend_cnt", 32'(pend_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    $display("reset phase done: checks=%0d", checks);

    // Every address reads zero and idle after reset.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(2*i), 5'(2*i+1), 1'b0, 5'd0, 1'b0);
      #1;
      chk("init_rdata0", rdata[31:0], 32'h0);
      chk("init_rdata1", rdata[63:32], 32'h0);
      chk("init_rbusy", 32'(rbusy), 32'h0);
      $display("init read r%0d/r%0d rdata=%h/%h rbusy=%b", 2*i, 2*i+1, rdata[31:0], rdata[63:32], rbusy);
      #1;
    end
    chk("init_pend_cnt", 32'(pend_cnt), 32'h0);

    // Table: combinational outputs checked mid-cycle, pend_cnt via queue after edge.
    for (int v = 0; v < 15; v++) begin
      @(negedge clk);
      drive(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].ra0, vecs[v].ra1,
            vecs[v].ie, vecs[v].ia, vecs[v].fl);
      #1;
      chk($sformatf("v%0d_rdata0", v), rdata[31:0], vecs[v].e_rd0);
      chk($sformatf("v%0d_rdata1", v), rdata[63:32], vecs[v].e_rd1);
      chk($sformatf("v%0d_rbusy", v), 32'(rbusy), 32'(vecs[v].e_busy));
      chk($sformatf("v%0d_issue_ready", v), 32'(issue_ready), 32'(vecs[v].e_ir));
      if (vecs[v].nz_chk) begin
        chk($sformatf("v%0d_nz_rdata0", v), rdata_nz[31:0], vecs[v].e_nz_rd0);
      end
      cnt_q.push_back(vecs[v].e_cnt);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pend_cnt", v), 32'(pend_cnt), 32'(cnt_q.pop_front()));
      $display("vec %0d: rdata=%h/%h rbusy=%b ready=%b pend_cnt=%0d", v,
               rdata[31:0], rdata[63:32], rbusy, issue_ready, pend_cnt);
    end

    // Reset asserted mid-cycle clears everything immediately.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd10, 1'b1, 5'd10, 1'b0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd10, 1'b1, 5'd11, 1'b0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd10, 1'b0, 5'd10, 1'b0);
    #1;
    chk("pre_rst_rdata0", rdata[31:0], 32'hDEADBEEF);
    chk("pre_rst_rbusy", 32'(rbusy), 32'h2);
    chk("pre_rst_pend_cnt", 32'(pend_cnt), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_pend_cnt", 32'(pend_cnt), 32'h0);
    chk("async_rst_rdata0", rdata[31:0], 32'h0);
    chk("async_rst_rbusy", 32'(rbusy), 32'h0);
    drive(1'b1, 5'd5, 32'h55, 5'd5, 5'd10, 1'b1, 5'd12, 1'b0);
    #1;
    chk("in_rst_bypass", rdata[31:0], 32'h0);
    chk("in_rst_issue_ready", 32'(issue_ready), 32'h1);
    @(posedge clk); #1;
    chk("in_rst_pend_cnt", 32'(pend_cnt), 32'h0);
    $display("mid-sequence reset: pend_cnt=%0d rdata0=%h", pend_cnt, rdata[31:0]);

    // First edge after release processes inputs normally.
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd12, 1'b0, 5'd12, 1'b0);
    #1;
    chk("post_rst_r5", rdata[31:0], 32'h0);
    drive(1'b1, 5'd5, 32'h77, 5'd5, 5'd12, 1'b1, 5'd12, 1'b0);
    cnt_q.push_back(6'd1);
    @(posedge clk); #1;
    chk("post_rst_pend_cnt", 32'(pend_cnt), 32'(cnt_q.pop_front()));
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd12, 1'b0, 5'd12, 1'b0);
    #1;
    chk("post_rst_rdata0", rdata[31:0], 32'h77);
    chk("post_rst_rbusy", 32'(rbusy), 32'h2);
    $display("post-reset: rdata0=%h rbusy=%b pend_cnt=%0d", rdata[31:0], rbusy, pend_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, meaning register address width, depth 2**ADDR_W.
REQ-003 SHALL provide parameter NUM_RD, default 2, meaning number of independent read ports.
REQ-004 SHALL provide parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL provide port we, input, 1, write enable.
REQ-008 SHALL provide port waddr, input, ADDR_W, write address.
REQ-009 SHALL provide port wdata, input, DATA_W, write data.
REQ-010 SHALL provide port raddr, input, NUM_RD*ADDR_W, packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 SHALL provide port rdata, output, NUM_RD*DATA_W, packed read data, same packing.
REQ-012 SHALL provide port rbusy, output, NUM_RD, read operand k not yet available.
REQ-013 SHALL provide port issue_en, input, 1, request to mark issue_addr pending.
REQ-014 SHALL provide port issue_addr, input, ADDR_W, destination register being issued.
REQ-015 SHALL provide port issue_ready, output, 1, issue_addr may be marked pending this cycle.
REQ-016 SHALL provide port flush, input, 1, clear all pending bits.
REQ-017 SHALL provide port pend_cnt, output, ADDR_W+1, registered count of pending registers.

Function
REQ-018 Write SHALL be synchronous: reg[waddr] <= wdata at rising clk when we=1; no combinational write path.
REQ-019 Read SHALL be combinational, zero latency, on every port independently.
REQ-020 Bypass: when we=1 and waddr==raddr_k, rdata_k SHALL equal wdata in the same cycle.
REQ-021 With ZERO_REG=1, address 0 SHALL read 0, ignore writes, never become pending, and give issue_ready=1; with ZERO_REG=0, register 0 SHALL behave like any other.
REQ-022 Scoreboard: pending[a] SHALL set at the clock edge when issue_en=1, issue_ready=1, issue_addr=a.
REQ-023 pending[a] SHALL clear at the clock edge when we=1 and waddr=a.
REQ-024 When issue and write target the same address in the same cycle, pending SHALL end set (the new producer wins).
REQ-025 issue_ready SHALL be !pending[issue_addr] || (we && waddr==issue_addr); issue_en with issue_ready=0 SHALL be ignored.
REQ-026 rbusy[k] SHALL be pending[raddr_k] && !(we && waddr==raddr_k).
REQ-027 flush=1 SHALL clear all pending bits at the edge, overriding a same-cycle issue; register contents SHALL be unaffected.
REQ-028 pend_cnt SHALL equal the population count of pending after each edge, never exceeding 2**ADDR_W-ZERO_REG.
REQ-029 Address arithmetic SHALL be unsigned ADDR_W bits with no wrap beyond depth.

Reset
REQ-030 reset=1 SHALL asynchronously clear all registers to 0, all pending bits, and pend_cnt to 0.
REQ-031 During reset, writes and issues SHALL be ignored; rdata SHALL read 0, rbusy SHALL be 0, and issue_ready SHALL be 1.
REQ-032 After reset deasserts mid-operation, the first edge SHALL process inputs normally.

Structure
REQ-033 Package regfile_pkg SHALL hold default DATA_W, ADDR_W, NUM_RD constants and a popcount function.
REQ-034 A sub-module rf_read_port (address compare, bypass mux, zero-reg mux, busy) SHALL be instantiated NUM_RD times.

Verification
REQ-035 Reset, then read all addresses -> rdata=0, rbusy=0, pend_cnt=0.
REQ-036 Write 0xDEADBEEF to r5 while raddr0=5 -> rdata0=0xDEADBEEF same cycle; next cycle without we -> still 0xDEADBEEF.
REQ-037 Issue r7, next cycle raddr1=7 -> rbusy1=1, issue_ready for r7=0, pend_cnt=1; write r7=0x12 -> rbusy1=0 same cycle, pend_cnt=0 after edge.
REQ-038 Same cycle: write r9 and issue r9 while r9 is pending -> issue_ready=1, r9 pending after edge, pend_cnt unchanged.
REQ-039 Write 0xFFFFFFFF to r0 and issue r0 -> rdata reads 0, r0 never pending; repeat with ZERO_REG=0 -> reads 0xFFFFFFFF.
REQ-040 Issue r1, r2, r3, then flush together with issue r4 -> pend_cnt=0, all rbusy=0; assert reset mid-sequence -> immediate clear.
